// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with registered one-cycle reads and a level irq.
// Optional build macro MMIO_TIMER_SNAPSHOT_EN adds a MTIME_HI shadow latched by MTIME_LO reads.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wenable,
   output logic [31:0] data_rdata,
   output logic        irq
);

   typedef enum logic [2:0] {
      OFF_MTIME_LO    = 3'd0,
      OFF_MTIME_HI    = 3'd1,
      OFF_MTIMECMP_LO = 3'd2,
      OFF_MTIMECMP_HI = 3'd3,
      OFF_CTRL        = 3'd4,
      OFF_STATUS      = 3'd5,
      OFF_RSVD6       = 3'd6,
      OFF_RSVD7       = 3'd7
   } reg_off_e;

   localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction

   logic [63:0] mtime_q, mtime_d, mtime_inc;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        en_q, en_d, ie_q, ie_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q, irq_d;
   logic [31:0] hi_rd;
   logic        sel, wr, tick, pend;
   reg_off_e    offset;
   logic [1:0]  unused_addr_bits;

   assign unused_addr_bits = data_addr[1:0];
   assign sel    = (data_addr[31:5] == BASE_ADDR[31:5]);
   assign offset = reg_off_e'(data_addr[4:2]);
   assign wr     = sel && (|data_wenable);
   assign pend   = (mtime_q >= mtimecmp_q);
   assign tick   = en_q && (pcnt_q == PCNT_MAX);

`ifdef MMIO_TIMER_SNAPSHOT_EN
   logic [31:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      // A HI write must also refresh the shadow so a following HI read sees it.
      if (wr && offset == OFF_MTIME_HI) shadow_d = mtime_d[63:32];
      else if (sel && offset == OFF_MTIME_LO && data_wenable == 4'b0000) shadow_d = mtime_q[63:32];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow_q <= '0;
      else        shadow_q <= shadow_d;
   end

   assign hi_rd = shadow_q;
`else
   assign hi_rd = mtime_q[63:32];
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      pcnt_d     = '0;
      mtime_inc  = mtime_q + 64'(tick);
      mtime_d    = mtime_inc;
      mtimecmp_d = mtimecmp_q;
      en_d       = en_q;
      ie_d       = ie_q;
      rdata_d    = '0;
      irq_d      = ie_q & pend;

      if (en_q && !tick) pcnt_d = pcnt_q + 16'd1;

      // Strobed bytes override the increment; the rest keep the incremented value.
      if (wr) begin
         case (offset)
            OFF_MTIME_LO:    mtime_d[31:0]     = merge_bytes(mtime_inc[31:0], data_wdata, data_wenable);
            OFF_MTIME_HI:    mtime_d[63:32]    = merge_bytes(mtime_inc[63:32], data_wdata, data_wenable);
            OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], data_wdata, data_wenable);
            OFF_MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], data_wdata, data_wenable);
            OFF_CTRL: if (data_wenable[0]) begin
               en_d = data_wdata[0];
               ie_d = data_wdata[1];
            end
            default: ;
         endcase
      end

      if (sel) begin
         case (offset)
            OFF_MTIME_LO:    rdata_d = mtime_q[31:0];
            OFF_MTIME_HI:    rdata_d = hi_rd;
            OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
            OFF_CTRL:        rdata_d = {30'd0, ie_q, en_q};
            OFF_STATUS:      rdata_d = {31'd0, pend};
            default:         rdata_d = '0;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         pcnt_q     <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         ie_q       <= ie_d;
         pcnt_q     <= pcnt_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign data_rdata = rdata_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: two instances (PRESCALE=4 and PRESCALE=1) on a shared bus.
// Read expectations go through a scoreboard queue; inline compares in each scenario task.
module tb_mmio_timer;

   localparam logic [31:0] BASE4 = 32'h0000_4000;
   localparam logic [31:0] BASE1 = 32'h0000_5000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [3:0]  data_wenable = '0;
   logic [31:0] rdata4, rdata1;
   logic        irq4, irq1;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   mmio_timer #(.BASE_ADDR(BASE4), .PRESCALE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_wenable(data_wenable), .data_rdata(rdata4), .irq(irq4));

   mmio_timer #(.BASE_ADDR(BASE1), .PRESCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_wenable(data_wenable), .data_rdata(rdata1), .irq(irq1));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      data_addr    = a;
      data_wdata   = d;
      data_wenable = be;
      @(negedge clk);
      data_wenable = 4'b0000;
   endtask

   task automatic bus_read(input logic [31:0] a, input bit which, output logic [31:0] d);
      data_addr    = a;
      data_wenable = 4'b0000;
      @(negedge clk);
      d = which ? rdata1 : rdata4;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] obs, exp;
      logic [31:0] defaults [7];
      defaults = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({irq1, irq4, rdata1, rdata4} !== 66'd0) begin
            errors++;
            $display("FAIL reset_hold: irq1=%b irq4=%b rdata1=%h rdata4=%h, want all 0", irq1, irq4, rdata1, rdata4);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) exp_q.push_back(defaults[i]);
      for (int i = 0; i < 7; i++) begin
         bus_read(BASE1 + 32'(4 * i), 1'b1, obs);
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp || irq1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_reg%0d: got %h irq=%b, want %h irq=0", i, obs, irq1, exp);
         end
      end
   endtask

   task automatic test_prescale();
      logic [31:0] obs, exp;
      bus_write(BASE4 + 32'h10, 32'h1, 4'hF);
      idle(40);
      exp_q.push_back(32'd10);
      bus_read(BASE4, 1'b0, obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL prescale_count: got %0d want %0d", obs, exp); end
      bus_write(BASE4 + 32'h10, 32'h0, 4'hF);
      idle(20);
      exp_q.push_back(32'd10);
      bus_read(BASE4, 1'b0, obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp || irq4 !== 1'b0) begin
         errors++; $display("FAIL prescale_hold: got %0d irq=%b want %0d irq=0", obs, irq4, exp);
      end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] obs, exp;
      bus_write(BASE1 + 32'h08, 32'hAABB_CCDD, 4'b0101);
      exp_q.push_back(32'hFFBB_FFDD);
      bus_read(BASE1 + 32'h08, 1'b1, obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL byte_lanes: got %h want %h", obs, exp); end
      checks++;
      if (rdata4 !== 32'h0) begin errors++; $display("FAIL unsel_rdata_zero: got %h want 0", rdata4); end
      bus_write(BASE1 + 32'h48, 32'h0000_0000, 4'hF);
      exp_q.push_back(32'hFFBB_FFDD);
      bus_read(BASE1 + 32'h08, 1'b1, obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL unsel_write: got %h want %h", obs, exp); end
   endtask

   task automatic test_irq();
      logic [31:0] obs, exp;
      bus_write(BASE1 + 32'h0C, 32'h0, 4'hF);
      bus_write(BASE1 + 32'h08, 32'd5, 4'hF);
      bus_write(BASE1 + 32'h00, 32'h0, 4'hF);
      bus_write(BASE1 + 32'h04, 32'h0, 4'hF);
      bus_write(BASE1 + 32'h10, 32'h3, 4'hF);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (irq1 !== 1'b0) begin errors++; $display("FAIL irq_early_k%0d: got %b want 0", k, irq1); end
      end
      for (int k = 5; k <= 6; k++) begin
         exp_q.push_back((k == 6) ? 32'd1 : 32'd0);
         bus_read(BASE1 + 32'h14, 1'b1, obs);
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp || irq1 !== exp[0]) begin
            errors++; $display("FAIL irq_edge_k%0d: status=%h irq=%b want status=%h irq=%b", k, obs, irq1, exp, exp[0]);
         end
      end
      bus_write(BASE1 + 32'h08, 32'd100, 4'hF);
      checks++;
      if (irq1 !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b want 1", irq1); end
      idle(1);
      checks++;
      if (irq1 !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq1); end
      bus_write(BASE1 + 32'h10, 32'h0, 4'hF);
   endtask

   task automatic test_carry_wrap();
      logic [31:0] obs, exp;
      bus_write(BASE1 + 32'h04, 32'h0, 4'hF);
      bus_write(BASE1 + 32'h00, 32'hFFFF_FFFE, 4'hF);
      bus_write(BASE1 + 32'h10, 32'h1, 4'hF);
      idle(1);
      bus_write(BASE1 + 32'h10, 32'h0, 4'hF);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      for (int i = 0; i < 2; i++) begin
         bus_read(BASE1 + 32'(4 * i), 1'b1, obs);
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp || irq1 !== 1'b0) begin
            errors++; $display("FAIL carry_w%0d: got %h irq=%b want %h irq=0", i, obs, irq1, exp);
         end
      end
      bus_write(BASE1 + 32'h04, 32'hFFFF_FFFF, 4'hF);
      bus_write(BASE1 + 32'h00, 32'hFFFF_FFFF, 4'hF);
      bus_write(BASE1 + 32'h10, 32'h1, 4'hF);
      bus_write(BASE1 + 32'h10, 32'h0, 4'hF);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      for (int i = 0; i < 2; i++) begin
         bus_read(BASE1 + 32'(4 * i), 1'b1, obs);
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL wrap_w%0d: got %h want %h", i, obs, exp); end
      end
   endtask

   task automatic test_collision_snapshot();
      logic [31:0] obs, exp;
      bus_write(BASE1 + 32'h10, 32'h1, 4'hF);
      bus_write(BASE1 + 32'h00, 32'h0000_0100, 4'hF);
      exp_q.push_back(32'h0000_0100);
      exp_q.push_back(32'h0000_0101);
      for (int i = 0; i < 2; i++) begin
         bus_read(BASE1, 1'b1, obs);
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL collision_r%0d: got %h want %h", i, obs, exp); end
      end
      bus_write(BASE1 + 32'h10, 32'h0, 4'hF);

      bus_write(BASE1 + 32'h04, 32'h0, 4'hF);
      bus_write(BASE1 + 32'h00, 32'hFFFF_FFFF, 4'hF);
      bus_write(BASE1 + 32'h10, 32'h1, 4'hF);
      exp_q.push_back(32'hFFFF_FFFF);
`ifdef MMIO_TIMER_SNAPSHOT_EN
      exp_q.push_back(32'h0);
`else
      exp_q.push_back(32'h1);
`endif
      for (int i = 0; i < 2; i++) begin
         bus_read(BASE1 + 32'(4 * i), 1'b1, obs);
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL snapshot_w%0d: got %h want %h", i, obs, exp); end
      end
      bus_write(BASE1 + 32'h10, 32'h0, 4'hF);
   endtask

   task automatic test_midcount_reset();
      logic [31:0] obs, exp;
      logic [31:0] defaults [6];
      defaults = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
      bus_write(BASE1 + 32'h0C, 32'h0, 4'hF);
      bus_write(BASE1 + 32'h08, 32'd2, 4'hF);
      bus_write(BASE1 + 32'h00, 32'h0, 4'hF);
      bus_write(BASE1 + 32'h10, 32'h3, 4'hF);
      idle(5);
      checks++;
      if (irq1 !== 1'b1 || rdata1 !== 32'h3) begin
         errors++; $display("FAIL pre_reset: irq=%b rdata=%h want irq=1 rdata=3", irq1, rdata1);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (irq1 !== 1'b0 || rdata1 !== 32'h0) begin
         errors++; $display("FAIL async_reset: irq=%b rdata=%h want irq=0 rdata=0", irq1, rdata1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) exp_q.push_back(defaults[i]);
      for (int i = 0; i < 6; i++) begin
         bus_read(BASE1 + 32'(4 * i), 1'b1, obs);
         exp = exp_q.pop_front();
         checks++;
         if (obs !== exp || irq1 !== 1'b0) begin
            errors++; $display("FAIL post_reset_reg%0d: got %h irq=%b want %h irq=0", i, obs, irq1, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_prescale();
      test_byte_lanes();
      test_irq();
      test_carry_wrap();
      test_collision_snapshot();
      test_midcount_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
Memory-mapped machine timer: the responder on the CPU data bus (addr/wdata/wenable/rdata), sitting beside the word RAM. Holds a 64-bit free-running counter (mtime) and a 64-bit compare register (mtimecmp). Drives the CPU `irq` input when mtime >= mtimecmp and the interrupt is enabled. Read timing matches the RAM: registered rdata, one-cycle latency.

Parameters:
BASE_ADDR, 32'h0000_4000, base of a 32-byte window; bits [4:0] must be 0
PRESCALE, 1, clocks per mtime increment; legal values 1..65535

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
data_addr  in  32  byte address from the CPU
data_wdata  in  32  write data
data_wenable  in  4  per-byte write strobes; bit i writes byte lane i
data_rdata  out  32  registered read data; 0 when not selected
irq  out  1  registered level interrupt request to the CPU

Behaviour:
- Select: sel = (data_addr[31:5] == BASE_ADDR[31:5]). Offset = data_addr[4:2].
- Register map (word offsets):
  - 0x00 MTIME_LO: rw
  - 0x04 MTIME_HI: rw
  - 0x08 MTIMECMP_LO: rw
  - 0x0C MTIMECMP_HI: rw
  - 0x10 CTRL: bit0 EN (count enable), bit1 IE (irq enable); other bits read 0
  - 0x14 STATUS: bit0 PEND = (mtime >= mtimecmp), read-only
  - 0x18, 0x1C: read 0, writes ignored
- Writes: take effect at the rising edge when sel && |data_wenable. Each strobed byte lane updates independently; unstrobed lanes keep their value. Writes with sel=0 are ignored.
- Reads:
  - data_rdata <= sel ? reg[offset] : 32'h0 every cycle. Valid the cycle after the address is presented.
  - The zero-when-unselected output lets the top level OR data_rdata with the RAM output.
  - Reads have no side effects (see optional feature).
  - On a same-cycle read and write, rdata returns the pre-write value.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 while EN=1; tick when pcnt == PRESCALE-1, then pcnt wraps to 0.
  - PRESCALE=1 gives a tick every cycle.
  - EN=0 holds mtime and forces pcnt to 0.
- Counter: on tick, mtime <= mtime + 1, 64-bit, wrapping from FFFF_FFFF_FFFF_FFFF to 0. The carry from LO into HI happens in the same cycle.
- Write/tick collision: a CPU write to a strobed byte of MTIME_LO/HI wins over the increment for that byte. Bytes not written take the incremented value.
- Compare: unsigned 64-bit, mtime >= mtimecmp.
- irq <= IE & (mtime >= mtimecmp), computed on current register values.
  - irq lags the compare condition by one cycle.
  - It is a level signal; it clears only by raising mtimecmp, lowering mtime, or clearing IE.
- Reset (async, rst_n=0): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, pcnt=0, data_rdata=0, irq=0. Deasserting reset mid-count restarts from these values; no pending state survives reset.

Optional Feature:
MMIO_TIMER_SNAPSHOT_EN
- Defined:
  - A read of MTIME_LO (sel, offset 0, no write strobes) latches mtime[63:32] into a shadow register in the same edge that captures LO.
  - Subsequent MTIME_HI reads return the shadow, giving a tear-free 64-bit read across a LO-to-HI carry.
  - The shadow resets to 0.
  - Writes to MTIME_HI update both mtime[63:32] and the shadow.
- Undefined: MTIME_HI reads return live mtime[63:32]; no shadow register is synthesized.

Test Plan:
1. Reset defaults: hold rst_n=0, release, read offsets 0x00–0x14 -> 0, 0, FFFFFFFF, FFFFFFFF, 0, 0 (STATUS=0); irq=0 throughout.
2. Prescaled counting: PRESCALE=4; write CTRL=1 at BASE+0x10; after 40 clocks read MTIME_LO -> 10 (±1 per the read latency); write CTRL=0, wait 20 clocks -> value unchanged.
3. Byte-lane writes: write MTIMECMP_LO=AABBCCDD with wenable=4'b0101 -> reads FFBBFFDD; with sel=0 (address BASE+0x40) -> no change.
4. IRQ: mtime=0, mtimecmp=5, CTRL=3, PRESCALE=1 -> irq rises exactly one cycle after mtime reaches 5 and STATUS=1; write MTIMECMP_LO=100 -> irq falls next cycle.
5. Carry/wrap: write MTIME_HI=0, MTIME_LO=FFFFFFFE, EN=1 -> after 2 ticks HI=1, LO=0; write HI=FFFFFFFF, LO=FFFFFFFF -> next tick mtime=0.
6. Collision and snapshot: write MTIME_LO=0x100 on a tick cycle -> LO reads 0x100, not 0x101. With MMIO_TIMER_SNAPSHOT_EN, LO=FFFFFFFF, HI=0: read LO, let the carry occur, read HI -> 0 (unchanged by the carry); without the macro -> 1. Assert rst_n mid-count -> all registers return to reset values asynchronously.
